// File: rtl/ip_stream_format_pipe_out_if.sv
// Shared types and the bundled port interface for ip_stream_format_pipe_out.
//
// ip_stream_format_pipe_out_pkg
//   ip_pkt_hdr           : 20-byte IPv4 header, version in the most significant nibble
//   tracker_stats_struct : per-packet timestamp carried alongside the data
//   fmt_state_e          : formatter FSM encoding (exposed on the debug port)
//
// ip_stream_format_pipe_out_if
//   Ingress FIFO (first-word-fall-through): data_fifo_out_empty, data_fifo_out_rd_data, out_data_fifo_rd_req
//   Checksum results                      : chksum_resp_val, chksum_resp_result, chksum_resp_rdy
//   Header channel (egress)               : ip_format_dst_rx_hdr_val/_ip_hdr/_timestamp, dst_ip_format_rx_hdr_rdy
//   Data channel (egress)                 : ip_format_dst_rx_data_val/_data/_last/_padbytes, dst_ip_format_rx_data_rdy
//   modport slave  : the formatter block
//   modport master : the environment around it (FIFO, checksum unit, destination)
//
// Handshakes: a transfer happens on a rising clock edge where val and rdy are both 1.
// The FIFO pop (rd_req) and the checksum consume (chksum_resp_rdy) act as the rdy side
// of their channels, with ~empty and chksum_resp_val as the matching valids.

package ip_stream_format_pipe_out_pkg;

  localparam int IP_HDR_W = 160;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [2:0]  flags;
    logic [12:0] frag_off;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] hdr_chksum;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
  } ip_pkt_hdr;

  typedef struct packed {
    logic [63:0] timestamp;
  } tracker_stats_struct;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_OUT  = 2'd1,
    DATA_OUT = 2'd2,
    DROP     = 2'd3
  } fmt_state_e;

endpackage

interface ip_stream_format_pipe_out_if
  import ip_stream_format_pipe_out_pkg::*;
#(
  parameter int DATA_WIDTH     = -1,
  parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH/8)
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [PADBYTES_WIDTH-1:0] padbytes;
    logic                      last;
    tracker_stats_struct       timestamp;
  } fifo_struct;

  // Ingress FIFO
  logic                      data_fifo_out_empty;
  fifo_struct                data_fifo_out_rd_data;
  logic                      out_data_fifo_rd_req;

  // Checksum results
  logic                      chksum_resp_val;
  logic [15:0]               chksum_resp_result;
  logic                      chksum_resp_rdy;

  // Header channel
  logic                      ip_format_dst_rx_hdr_val;
  ip_pkt_hdr                 ip_format_dst_rx_ip_hdr;
  tracker_stats_struct       ip_format_dst_rx_timestamp;
  logic                      dst_ip_format_rx_hdr_rdy;

  // Data channel
  logic                      ip_format_dst_rx_data_val;
  logic [DATA_WIDTH-1:0]     ip_format_dst_rx_data;
  logic                      ip_format_dst_rx_last;
  logic [PADBYTES_WIDTH-1:0] ip_format_dst_rx_padbytes;
  logic                      dst_ip_format_rx_data_rdy;

  modport slave (
    input  data_fifo_out_empty, data_fifo_out_rd_data,
    input  chksum_resp_val, chksum_resp_result,
    input  dst_ip_format_rx_hdr_rdy, dst_ip_format_rx_data_rdy,
    output out_data_fifo_rd_req, chksum_resp_rdy,
    output ip_format_dst_rx_hdr_val, ip_format_dst_rx_ip_hdr, ip_format_dst_rx_timestamp,
    output ip_format_dst_rx_data_val, ip_format_dst_rx_data, ip_format_dst_rx_last,
    output ip_format_dst_rx_padbytes
  );

  modport master (
    output data_fifo_out_empty, data_fifo_out_rd_data,
    output chksum_resp_val, chksum_resp_result,
    output dst_ip_format_rx_hdr_rdy, dst_ip_format_rx_data_rdy,
    input  out_data_fifo_rd_req, chksum_resp_rdy,
    input  ip_format_dst_rx_hdr_val, ip_format_dst_rx_ip_hdr, ip_format_dst_rx_timestamp,
    input  ip_format_dst_rx_data_val, ip_format_dst_rx_data, ip_format_dst_rx_last,
    input  ip_format_dst_rx_padbytes
  );

endinterface

// File: rtl/ip_stream_format_pipe_out.sv
// IP stream formatter, egress side.
//
// Pairs each packet in the ingress FIFO with its header checksum result. Packets whose
// checksum folds to zero and whose header is a plausible IPv4 header (version 4, IHL >= 5)
// are emitted as one header beat followed by every FIFO line of the packet; any other
// packet is popped from the FIFO silently and counted as dropped.
//
// Ports
//   clk                : sole clock, rising edge
//   rst                : asynchronous reset, active low
//   bus                : ip_stream_format_pipe_out_if.slave (FIFO, checksum, header, data channels)
//   ip_format_drop_cnt : dropped-packet count, saturating at 32'hFFFF_FFFF
//   dbg_state          : current FSM state

module ip_stream_format_pipe_out
  import ip_stream_format_pipe_out_pkg::*;
#(
  parameter int DATA_WIDTH     = -1,
  parameter int PADBYTES_WIDTH = $clog2(DATA_WIDTH/8)
) (
  input  logic                         clk,
  input  logic                         rst,
  ip_stream_format_pipe_out_if.slave   bus,
  output logic [31:0]                  ip_format_drop_cnt,
  output fmt_state_e                   dbg_state
);

  fmt_state_e          state_q, state_d;
  ip_pkt_hdr           hdr_q, hdr_d;
  tracker_stats_struct ts_q, ts_d;
  logic [31:0]         drop_cnt_q, drop_cnt_d;

  ip_pkt_hdr                 head_hdr;
  logic [PADBYTES_WIDTH-1:0] head_pad;
  logic                      head_valid;
  logic                      head_last;
  logic                      eval;
  logic                      pass;

  logic hdr_val;
  logic data_val;
  logic rd_req;
  logic cr_rdy;

  // The IPv4 header sits in the most significant bytes of the first line of a packet.
  assign head_hdr   = bus.data_fifo_out_rd_data.data[DATA_WIDTH-1 -: IP_HDR_W];
  assign head_pad   = bus.data_fifo_out_rd_data.padbytes;
  assign head_last  = bus.data_fifo_out_rd_data.last;
  assign head_valid = ~bus.data_fifo_out_empty;

  // A decision is taken only once both the first line and its checksum result are present.
  assign eval = head_valid & bus.chksum_resp_val;
  assign pass = (bus.chksum_resp_result == 16'h0000) &
                (head_hdr.version == 4'd4) &
                (head_hdr.ihl >= 4'd5);

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    ts_d       = ts_q;
    drop_cnt_d = drop_cnt_q;
    hdr_val    = 1'b0;
    data_val   = 1'b0;
    rd_req     = 1'b0;
    cr_rdy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (eval) begin
          cr_rdy = 1'b1;
          if (pass) begin
            // The first line stays in the FIFO; it is sent again as data beat 0.
            hdr_d   = head_hdr;
            ts_d    = bus.data_fifo_out_rd_data.timestamp;
            state_d = HDR_OUT;
          end else begin
            if (drop_cnt_q != 32'hFFFF_FFFF) begin
              drop_cnt_d = drop_cnt_q + 32'd1;
            end
            state_d = DROP;
          end
        end
      end

      HDR_OUT: begin
        hdr_val = 1'b1;
        if (bus.dst_ip_format_rx_hdr_rdy) begin
          state_d = DATA_OUT;
        end
      end

      DATA_OUT: begin
        data_val = head_valid;
        rd_req   = data_val & bus.dst_ip_format_rx_data_rdy;
        if (rd_req & head_last) begin
          state_d = IDLE;
        end
      end

      DROP: begin
        rd_req = head_valid;
        if (rd_req & head_last) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      ts_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      ts_q       <= ts_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Strobes are gated with rst so they drop the instant reset asserts, even while the
  // FIFO and checksum inputs still look ready to the IDLE evaluation.
  assign bus.out_data_fifo_rd_req      = rd_req & rst;
  assign bus.chksum_resp_rdy           = cr_rdy & rst;
  assign bus.ip_format_dst_rx_hdr_val  = hdr_val & rst;
  assign bus.ip_format_dst_rx_data_val = data_val & rst;

  assign bus.ip_format_dst_rx_ip_hdr    = hdr_q;
  assign bus.ip_format_dst_rx_timestamp = ts_q;

  // Data beats are the FIFO head as-is, including the header bytes of the first line.
  assign bus.ip_format_dst_rx_data     = bus.data_fifo_out_rd_data.data;
  assign bus.ip_format_dst_rx_last     = head_last;
  assign bus.ip_format_dst_rx_padbytes = head_pad;

  assign ip_format_drop_cnt = drop_cnt_q;
  assign dbg_state          = state_q;

endmodule

// File: doc/ip_stream_format_pipe_out.md
IP_STREAM_FORMAT_PIPE_OUT -- requirements
Module: ip_stream_format_pipe_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default -1, meaning the line width in bits; it must be overridden with 256 or 512.
REQ-002 SHALL have derived parameter PADBYTES_WIDTH, default $clog2(DATA_WIDTH/8), meaning the padbytes field width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low (asserted when 0).
REQ-005 SHALL have port data_fifo_out_empty  input  1  ingress data FIFO empty.
REQ-006 SHALL have port data_fifo_out_rd_data  input  fifo_struct  FWFT head entry: data, padbytes, last, timestamp.
REQ-007 SHALL have port out_data_fifo_rd_req  output  1  pop FIFO head.
REQ-008 SHALL have port chksum_resp_val  input  1  IP header checksum result valid, one per packet, in packet order.
REQ-009 SHALL have port chksum_resp_result  input  16  folded ones-complement header sum; 16'h0000 = pass.
REQ-010 SHALL have port chksum_resp_rdy  output  1  checksum result consumed.
REQ-011 SHALL have ports ip_format_dst_rx_hdr_val  output  1, ip_format_dst_rx_ip_hdr  output  ip_pkt_hdr, ip_format_dst_rx_timestamp  output  tracker_stats_struct, and dst_ip_format_rx_hdr_rdy  input  1, forming the header channel.
REQ-012 SHALL have ports ip_format_dst_rx_data_val  output  1, ip_format_dst_rx_data  output  DATA_WIDTH, ip_format_dst_rx_last  output  1, ip_format_dst_rx_padbytes  output  PADBYTES_WIDTH, and dst_ip_format_rx_data_rdy  input  1, forming the data channel.
REQ-013 SHALL have port ip_format_drop_cnt  output  32  count of dropped packets, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, HDR_OUT, DATA_OUT, DROP.
REQ-015 IDLE: SHALL evaluate only when ~data_fifo_out_empty & chksum_resp_val, with header = data[DATA_WIDTH-1 -: IP_HDR_W] of the head line.
REQ-016 IDLE: a packet SHALL pass iff result==16'h0000 & version==4 & ip_hdr_len>=5.
REQ-017 IDLE pass: SHALL pulse chksum_resp_rdy, register header and timestamp, go to HDR_OUT; no FIFO pop.
REQ-018 IDLE fail: SHALL pulse chksum_resp_rdy, increment drop_cnt (saturate at 32'hFFFF_FFFF), go to DROP.
REQ-019 HDR_OUT: SHALL drive hdr_val=1 from registers, held stable until dst_ip_format_rx_hdr_rdy; on handshake go to DATA_OUT.
REQ-020 DATA_OUT: data_val SHALL equal ~empty; data/last/padbytes SHALL pass through combinationally from the FIFO head, full line including the IP header bytes.
REQ-021 DATA_OUT: rd_req SHALL equal data_val & data_rdy; a pop with last=1 SHALL return the FSM to IDLE.
REQ-022 DROP: rd_req SHALL equal ~empty; data_val SHALL be 0; a pop with last=1 SHALL go to IDLE.
REQ-023 Header latency SHALL be 1 cycle from IDLE evaluation to hdr_val=1; data throughput SHALL be one line/cycle with no bubbles between consecutive packets other than the IDLE and HDR_OUT cycles.
REQ-024 A single-line packet (last on the first line) SHALL traverse HDR_OUT then DATA_OUT for exactly one beat.
REQ-025 chksum_resp_rdy SHALL be 0 outside IDLE; outputs SHALL NOT depend on chksum_resp_val outside IDLE.
REQ-026 Empty FIFO mid-packet SHALL stall with data_val=0 and no state change.

Reset
REQ-027 Reset assertion SHALL immediately force state=IDLE, drop_cnt=0, and all val/rdy/rd_req outputs=0, even mid-packet.
REQ-028 Registered header/timestamp SHALL be reset to 0.
REQ-029 After deassertion the first evaluated line SHALL be treated as a packet start.

Verification
REQ-030 DATA_WIDTH=512; valid 3-line packet with ihl=5, result 0, rdy=1 -> hdr_val in cycle 1, 3 data beats, last on beat 3, drop_cnt=0.
REQ-031 Packet with result 16'h1234 -> no hdr_val and no data_val; all lines popped; drop_cnt=1; next valid packet passes normally.
REQ-032 version=6 or ihl=4 with result 0 -> dropped, drop_cnt increments.
REQ-033 hdr_rdy low for 5 cycles, then data_rdy toggling 1/0 -> header stable and unpopped, no line lost or duplicated, rd_req only on val&rdy.
REQ-034 Back-to-back single-line packets, FIFO never empty -> each costs IDLE+HDR_OUT+1 data cycle; order preserved; padbytes passed unchanged.
REQ-035 rst driven low during beat 2 of a 4-line packet -> outputs 0 asynchronously; after release, drop_cnt=0 and state=IDLE.
